// File: rtl/ula_pkg.sv
// ula_pkg: shared constants for the arbitrated ALU.
//   - LARGURA_PADRAO : default operand/result width
//   - ULA_* opcodes  : 3-bit ALU operation codes
//   - OCIOSO/EXECUTA/RESPONDE : FSM state encoding of ula_arbitro
package ula_pkg;

    localparam int unsigned LARGURA_PADRAO = 16;

    localparam logic [2:0] ULA_SOMA  = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_AND   = 3'b010;
    localparam logic [2:0] ULA_OR    = 3'b011;
    localparam logic [2:0] ULA_NOT   = 3'b100;
    localparam logic [2:0] ULA_SHR   = 3'b101;
    localparam logic [2:0] ULA_SHL   = 3'b110;
    localparam logic [2:0] ULA_PASSA = 3'b111;

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] EXECUTA  = 2'd1;
    localparam logic [1:0] RESPONDE = 2'd2;

endpackage

// File: rtl/ula.sv
// ula: purely combinational ALU.
//   i_sel : opcode (ULA_* from ula_pkg)
//   i_x   : operand X
//   i_y   : operand Y
//   o_res : result, add/sub wrap modulo 2^LARGURA
module ula
    import ula_pkg::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic [2:0]         i_sel,
    input  logic [LARGURA-1:0] i_x,
    input  logic [LARGURA-1:0] i_y,
    output logic [LARGURA-1:0] o_res
);

    always_comb begin
        o_res = '0;
        case (i_sel)
            ULA_SOMA:  o_res = i_x + i_y;
            ULA_SUB:   o_res = i_x - i_y;
            ULA_AND:   o_res = i_x & i_y;
            ULA_OR:    o_res = i_x | i_y;
            ULA_NOT:   o_res = ~i_x;
            ULA_SHR:   o_res = i_x >> 1;
            ULA_SHL:   o_res = i_x << 1;
            ULA_PASSA: o_res = i_x;
            default:   o_res = '0;
        endcase
    end

endmodule

// File: rtl/ula_arbitro.sv
// ula_arbitro: two-requester arbiter in front of a single registered ALU.
// Ports:
//   clock, reset        : clock; synchronous active-high reset
//   req0/req1           : operation requests
//   sel0/sel1, x0/x1, y0/y1 : opcode and operands per requester
//   gnt0/gnt1           : combinational acceptance strobes (only in OCIOSO)
//   resultado, N, Z     : registered result and its negative/zero flags
//   valido, dono        : response valid and owning requester
//   ack                 : consumer accepts the response
//   ocupado             : FSM not idle
// Configuration macro: ULA_ARB_PRIO_FIXA_EN -- when defined, requester 0 always
// wins simultaneous requests; otherwise round-robin alternates after each response.
module ula_arbitro
    import ula_pkg::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0,
    input  logic               req1,
    input  logic [2:0]         sel0,
    input  logic [2:0]         sel1,
    input  logic [LARGURA-1:0] x0,
    input  logic [LARGURA-1:0] x1,
    input  logic [LARGURA-1:0] y0,
    input  logic [LARGURA-1:0] y1,
    output logic               gnt0,
    output logic               gnt1,
    output logic [LARGURA-1:0] resultado,
    output logic               N,
    output logic               Z,
    output logic               valido,
    output logic               dono,
    input  logic               ack,
    output logic               ocupado
);

    logic [1:0]         r_estado;
    logic [2:0]         r_sel;
    logic [LARGURA-1:0] r_x;
    logic [LARGURA-1:0] r_y;
    logic               r_dono;
    logic [LARGURA-1:0] r_resultado;
    logic               r_n;
    logic               r_z;
    logic               r_valido;
    logic [LARGURA-1:0] w_res;
`ifndef ULA_ARB_PRIO_FIXA_EN
    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic               r_ptr;
`endif

    // Grants are only offered while idle and out of reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && (r_estado == OCIOSO)) begin
            if (req0 && req1) begin
`ifdef ULA_ARB_PRIO_FIXA_EN
                gnt0 = 1'b1;
`else
                if (r_ptr) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
`endif
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    ula #(
        .LARGURA (LARGURA)
    ) u_ula (
        .i_sel (r_sel),
        .i_x   (r_x),
        .i_y   (r_y),
        .o_res (w_res)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_sel       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_dono      <= 1'b0;
            r_resultado <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_valido    <= 1'b0;
`ifndef ULA_ARB_PRIO_FIXA_EN
            r_ptr       <= 1'b0;
`endif
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (req0 && gnt0) begin
                        r_sel    <= sel0;
                        r_x      <= x0;
                        r_y      <= y0;
                        r_dono   <= 1'b0;
                        r_estado <= EXECUTA;
                    end else if (req1 && gnt1) begin
                        r_sel    <= sel1;
                        r_x      <= x1;
                        r_y      <= y1;
                        r_dono   <= 1'b1;
                        r_estado <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    r_resultado <= w_res;
                    r_n         <= w_res[LARGURA-1];
                    r_z         <= (w_res == '0);
                    r_valido    <= 1'b1;
                    r_estado    <= RESPONDE;
                end
                RESPONDE: begin
                    if (ack) begin
                        r_valido <= 1'b0;
`ifndef ULA_ARB_PRIO_FIXA_EN
                        r_ptr    <= ~r_dono;
`endif
                        r_estado <= OCIOSO;
                    end
                end
                default: begin
                    r_valido <= 1'b0;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign resultado = r_resultado;
    assign N         = r_n;
    assign Z         = r_z;
    assign valido    = r_valido;
    assign dono      = r_dono;
    assign ocupado   = (r_estado != OCIOSO);

endmodule

// File: doc/ula_arbitro.md
ULA_ARBITRO -- requirements
Module: ula_arbitro

Interface
REQ-001 SHALL have parameter LARGURA, default 16, operand/result width in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  operation request from requester 0/1.
REQ-005 SHALL have ports sel0/sel1  input  3  ALU opcode from requester 0/1.
REQ-006 SHALL have ports x0/x1, y0/y1  input  LARGURA  operands from requester 0/1.
REQ-007 SHALL have ports gnt0/gnt1  output  1  acceptance strobe to requester 0/1.
REQ-008 SHALL have port resultado  output  LARGURA  registered ALU result.
REQ-009 SHALL have ports N, Z  output  1  registered negative/zero flags of resultado.
REQ-010 SHALL have port valido  output  1  resultado/N/Z/dono hold a valid response.
REQ-011 SHALL have port dono  output  1  index of requester owning the current response.
REQ-012 SHALL have port ack  input  1  consumer accepts the current response.
REQ-013 SHALL have port ocupado  output  1  high whenever state is not OCIOSO.

Function
REQ-014 SHALL implement FSM states OCIOSO, EXECUTA, RESPONDE.
REQ-015 In OCIOSO, gnt0/gnt1 SHALL be driven combinationally, at most one high, only to a requester with req high; both low in other states.
REQ-016 Acceptance SHALL occur at an edge with reqN & gntN: sel, x, y of the winner latched, dono set, state -> EXECUTA.
REQ-017 With both req high, the winner SHALL be the requester indicated by the round-robin pointer; with one req high, that requester wins regardless of pointer.
REQ-018 In EXECUTA, the ALU SHALL evaluate the latched operands; at the next edge resultado, N (= result MSB), Z (= all LARGURA bits zero) SHALL be registered, valido set, state -> RESPONDE.
REQ-019 Opcodes SHALL be: 000 X+Y, 001 X-Y, 010 X&Y, 011 X|Y, 100 ~X, 101 X>>1 logical, 110 X<<1, 111 X; add/sub wrap modulo 2^LARGURA, carry discarded.
REQ-020 In RESPONDE, resultado, N, Z, dono SHALL hold stable until an edge with ack high; at that edge valido clears, pointer set to favour the other requester (~dono), state -> OCIOSO.
REQ-021 ack SHALL be ignored in OCIOSO and EXECUTA; req/sel/x/y changes after acceptance SHALL not affect the operation in flight.
REQ-022 Latency SHALL be 2 edges from acceptance to valido high; with ack tied high, throughput one operation per 3 cycles.
REQ-023 resultado/N/Z SHALL retain their last value after valido clears.

Reset
REQ-024 At a reset edge (any state, including mid-operation) SHALL set state OCIOSO, pointer to requester 0, resultado 0, N 0, Z 0, valido 0, dono 0; in-flight operation discarded.
REQ-025 While reset high, gnt0/gnt1 SHALL be low.

Configuration
REQ-026 Macro ULA_ARB_PRIO_FIXA_EN: when defined, requester 0 SHALL always win simultaneous requests and the pointer is unused; when undefined, round-robin per REQ-017/REQ-020 applies.

Structure
REQ-027 Package ula_pkg SHALL hold opcode constants (ULA_SOMA, ULA_SUB, ULA_AND, ULA_OR, ULA_NOT, ULA_SHR, ULA_SHL, ULA_PASSA), FSM state encoding, default LARGURA.
REQ-028 The combinational ALU SHALL be the single sub-module ULA, instantiated once and fed from the latched operand registers.

Verification
REQ-029 Reset then req0=1, sel0=000, x0=0x0003, y0=0x0004, ack=1 -> gnt0 in accept cycle; resultado=0x0007, N=0, Z=0, valido=1, dono=0 two edges later.
REQ-030 req1=1, sel1=001, x1=0x0005, y1=0x0005 -> resultado=0x0000, Z=1, N=0, dono=1; sel1=001, x1=0x0000, y1=0x0001 -> resultado=0xFFFF, N=1, Z=0.
REQ-031 req0=req1=1 held, ack=1, macro undefined -> grants alternate 0,1,0,1 after reset; macro defined -> gnt0 every operation.
REQ-032 Response pending, ack=0 for 5 cycles -> valido, resultado, dono stable, ocupado=1, no gnt; ack=1 -> valido 0 next edge, OCIOSO.
REQ-033 Reset asserted in EXECUTA -> next edge valido=0, resultado=0, OCIOSO; operation never reported.
REQ-034 Sweep all 8 opcodes with x=0x8001, y=0x0003 -> 0x8004, 0x7FFE, 0x0001, 0x8003, 0x7FFE, 0x4000, 0x0002, 0x8001.
